// File: rtl/param_barrel_pkg.sv
// param_barrel_pkg
//   Shared types and helpers for the param_barrel block.
//   state_t  : control FSM encoding (IDLE = idle/rotate, LOAD = streaming fill)
//   mod_add  : (a + b) mod n, for 0 <= a, b < n
//   mod_sub  : (a - b) mod n, for 0 <= a, b < n
package param_barrel_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      LOAD = 1'b1
   } state_t;

   function automatic int mod_add(input int a, input int b, input int n);
      return (a + b) % n;
   endfunction

   // Adding n first keeps the intermediate non-negative.
   function automatic int mod_sub(input int a, input int b, input int n);
      return (a - b + n) % n;
   endfunction

endpackage

// File: rtl/param_barrel_inv_check.sv
// barrel_inv_check
//   Purely combinational neighbour-invariant checker over two N-entry arrays:
//   for all i, j: r(i) == b(j) implies r(i+1 mod N) == b(j+1 mod N).
//   Also usable directly as an assertion body.
//   Ports:
//     b_flat  in  N*W  shift-ring contents, entry i at [i*W +: W]
//     r_flat  in  N*W  register-file contents, entry i at [i*W +: W]
//     ok      out 1    1 when every one of the N*N implication terms holds
module barrel_inv_check
   import param_barrel_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N*W-1:0] b_flat,
   input  logic [N*W-1:0] r_flat,
   output logic           ok
);

   always_comb begin
      ok = 1'b1;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if ((r_flat[i*W +: W] == b_flat[j*W +: W]) &&
                (r_flat[mod_add(i, 1, N)*W +: W] != b_flat[mod_add(j, 1, N)*W +: W])) begin
               ok = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/param_barrel.sv
// param_barrel
//   N-entry rotating shift ring b plus N-entry holding register file r, both
//   filled through one streaming load port, with a built-in neighbour-
//   invariant monitor.
//   Ports:
//     clock       in   1     rising-edge clock
//     reset       in   1     asynchronous, active-high reset
//     en          in   1     rotate request (IDLE only)
//     dir         in   1     0 = rotate up, 1 = rotate down
//     amt         in   AW    rotate amount, reduced modulo N
//     load_start  in   1     begin a fill (IDLE only, wins over en)
//     load_valid  in   1     load beat valid
//     load_ready  out  1     high in LOAD
//     load_data   in   W     beat value, written to b[cnt] and r[cnt]
//     busy        out  1     high while not in IDLE (direct decode of the FSM state)
//     offset      out  AW    cumulative rotation of b since the last load, mod N
//     b_flat      out  N*W   ring contents, entry i at [i*W +: W]
//     r_flat      out  N*W   register-file contents, entry i at [i*W +: W]
//     inv_ok      out  1     invariant result, one cycle behind the arrays
//     inv_err     out  1     sticky violation, cleared by reset or load_start
module param_barrel
   import param_barrel_pkg::*;
#(
   parameter  int N  = 4,
   parameter  int W  = ($clog2(N) < 1) ? 1 : $clog2(N),
   localparam int AW = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           en,
   input  logic           dir,
   input  logic [AW-1:0]  amt,
   input  logic           load_start,
   input  logic           load_valid,
   output logic           load_ready,
   input  logic [W-1:0]   load_data,
   output logic           busy,
   output logic [AW-1:0]  offset,
   output logic [N*W-1:0] b_flat,
   output logic [N*W-1:0] r_flat,
   output logic           inv_ok,
   output logic           inv_err
);

   state_t        state;
   logic [AW-1:0] cnt;
   logic [AW-1:0] offset_q;
   logic [AW-1:0] offset_nxt;
   logic [W-1:0]  b_q   [N];
   logic [W-1:0]  r_q   [N];
   logic [W-1:0]  b_rot [N];
   logic          inv_ok_q;
   logic          inv_err_q;
   logic          prev_idle;
   logic          chk_ok;
   logic          accept;
   int            k;

   // Load handshake: a beat transfers on a rising edge where load_valid and
   // load_ready are both high. load_ready depends on state only, never on
   // load_valid; the source holds load_data stable while load_valid is high
   // and load_ready is low.
   assign load_ready = (state == LOAD);
   assign busy       = (state != IDLE);
   assign accept     = load_valid && load_ready;
   assign offset     = offset_q;
   assign inv_ok     = inv_ok_q;
   assign inv_err    = inv_err_q;

   // Rotation candidate and updated offset; used only when a rotate is taken.
   always_comb begin
      k = 32'(amt);
      k = k % N;
      for (int i = 0; i < N; i++) begin
         if (dir) b_rot[i] = b_q[AW'(mod_sub(i, k, N))];
         else     b_rot[i] = b_q[AW'(mod_add(i, k, N))];
      end
      if (dir) offset_nxt = AW'(mod_sub(32'(offset_q), k, N));
      else     offset_nxt = AW'(mod_add(32'(offset_q), k, N));
   end

   always_comb begin
      b_flat = '0;
      r_flat = '0;
      for (int i = 0; i < N; i++) begin
         b_flat[i*W +: W] = b_q[i];
         r_flat[i*W +: W] = r_q[i];
      end
   end

   barrel_inv_check #(
      .N (N),
      .W (W)
   ) u_inv_check (
      .b_flat (b_flat),
      .r_flat (r_flat),
      .ok     (chk_ok)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         offset_q  <= '0;
         inv_ok_q  <= 1'b1;
         inv_err_q <= 1'b0;
         prev_idle <= 1'b1;
         for (int i = 0; i < N; i++) begin
            b_q[i] <= '0;
            r_q[i] <= '0;
         end
      end else begin
         prev_idle <= (state == IDLE);
         inv_ok_q  <= chk_ok;
         case (state)
            IDLE: begin
               if (load_start) begin
                  state     <= LOAD;
                  cnt       <= '0;
                  offset_q  <= '0;
                  inv_err_q <= 1'b0;
               end else begin
                  if (en) begin
                     b_q      <= b_rot;
                     offset_q <= offset_nxt;
                  end
                  // Requiring two consecutive IDLE cycles keeps the monitor
                  // off the arrays while a fill is only partly written.
                  if (!chk_ok && prev_idle) inv_err_q <= 1'b1;
               end
            end
            LOAD: begin
               if (accept) begin
                  b_q[cnt] <= load_data;
                  r_q[cnt] <= load_data;
                  if (cnt == AW'(N - 1)) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_param_barrel.sv
// tb_param_barrel
//   Directed bench for param_barrel at N=4, W=2. Inputs change on the falling
//   edge and outputs are sampled there too, half a cycle after the active edge.
//   Packed array values list entry 3 in the top bits: b = 1,2,3,0 -> 8'h39.
module tb_param_barrel;

   logic       clock = 1'b0;
   logic       reset;
   logic       en;
   logic       dir;
   logic [1:0] amt;
   logic       load_start;
   logic       load_valid;
   logic       load_ready;
   logic [1:0] load_data;
   logic       busy;
   logic [1:0] offset;
   logic [7:0] b_flat;
   logic [7:0] r_flat;
   logic       inv_ok;
   logic       inv_err;

   int n_vec = 0;
   int n_err = 0;

   param_barrel #(.N(4), .W(2)) dut (
      .clock      (clock),
      .reset      (reset),
      .en         (en),
      .dir        (dir),
      .amt        (amt),
      .load_start (load_start),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .busy       (busy),
      .offset     (offset),
      .b_flat     (b_flat),
      .r_flat     (r_flat),
      .inv_ok     (inv_ok),
      .inv_err    (inv_err)
   );

   // ---------------- clock ----------------
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   // ---------------- drivers ----------------
   task automatic idle_inputs();
      en         = 1'b0;
      dir        = 1'b0;
      amt        = 2'd0;
      load_start = 1'b0;
      load_valid = 1'b0;
      load_data  = 2'd0;
   endtask

   // Entered and left on a falling edge; four back-to-back beats.
   task automatic fill(input logic [7:0] vals);
      load_start = 1'b1;
      @(negedge clock);
      load_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1;
         load_data  = vals[i*2 +: 2];
         @(negedge clock);
      end
      load_valid = 1'b0;
   endtask

   task automatic rotate(input logic d, input logic [1:0] a);
      en  = 1'b1;
      dir = d;
      amt = a;
      @(negedge clock);
      en  = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      n_vec++; if (b_flat !== 8'h00) begin n_err++; $display("FAIL reset_b got %h exp %h", b_flat, 8'h00); end
      n_vec++; if (r_flat !== 8'h00) begin n_err++; $display("FAIL reset_r got %h exp %h", r_flat, 8'h00); end
      n_vec++; if (offset !== 2'd0) begin n_err++; $display("FAIL reset_offset got %0d exp 0", offset); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_vec++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", load_ready); end
      n_vec++; if (inv_ok !== 1'b1) begin n_err++; $display("FAIL reset_inv_ok got %b exp 1", inv_ok); end
      n_vec++; if (inv_err !== 1'b0) begin n_err++; $display("FAIL reset_inv_err got %b exp 0", inv_err); end
      reset = 1'b0;
      @(negedge clock);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy got %b exp 0", busy); end
      n_vec++; if (inv_ok !== 1'b1) begin n_err++; $display("FAIL post_reset_inv_ok got %b exp 1", inv_ok); end
   endtask

   task automatic test_fill_rotate_up();
      fill(8'hE4);
      n_vec++; if (b_flat !== 8'hE4) begin n_err++; $display("FAIL fill_b got %h exp %h", b_flat, 8'hE4); end
      n_vec++; if (r_flat !== 8'hE4) begin n_err++; $display("FAIL fill_r got %h exp %h", r_flat, 8'hE4); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL fill_busy got %b exp 0", busy); end
      @(negedge clock);
      n_vec++; if (inv_ok !== 1'b1) begin n_err++; $display("FAIL fill_inv_ok got %b exp 1", inv_ok); end
      rotate(1'b0, 2'd1);
      n_vec++; if (b_flat !== 8'h39) begin n_err++; $display("FAIL up1_b got %h exp %h", b_flat, 8'h39); end
      n_vec++; if (r_flat !== 8'hE4) begin n_err++; $display("FAIL up1_r got %h exp %h", r_flat, 8'hE4); end
      n_vec++; if (offset !== 2'd1) begin n_err++; $display("FAIL up1_offset got %0d exp 1", offset); end
      @(negedge clock);
      n_vec++; if (inv_ok !== 1'b1) begin n_err++; $display("FAIL up1_inv_ok got %b exp 1", inv_ok); end
      n_vec++; if (inv_err !== 1'b0) begin n_err++; $display("FAIL up1_inv_err got %b exp 0", inv_err); end
   endtask

   task automatic test_back_to_back();
      fill(8'hE4);
      n_vec++; if (offset !== 2'd0) begin n_err++; $display("FAIL refill_offset got %0d exp 0", offset); end
      en  = 1'b1;
      dir = 1'b1;
      amt = 2'd3;
      @(negedge clock);
      n_vec++; if (b_flat !== 8'h39) begin n_err++; $display("FAIL down3_b got %h exp %h", b_flat, 8'h39); end
      n_vec++; if (offset !== 2'd1) begin n_err++; $display("FAIL down3_offset got %0d exp 1", offset); end
      dir = 1'b0;
      amt = 2'd2;
      @(negedge clock);
      n_vec++; if (b_flat !== 8'h93) begin n_err++; $display("FAIL up2_b got %h exp %h", b_flat, 8'h93); end
      n_vec++; if (offset !== 2'd3) begin n_err++; $display("FAIL up2_offset got %0d exp 3", offset); end
      amt = 2'd0;
      @(negedge clock);
      en = 1'b0;
      n_vec++; if (b_flat !== 8'h93) begin n_err++; $display("FAIL amt0_b got %h exp %h", b_flat, 8'h93); end
      n_vec++; if (offset !== 2'd3) begin n_err++; $display("FAIL amt0_offset got %0d exp 3", offset); end
      n_vec++; if (r_flat !== 8'hE4) begin n_err++; $display("FAIL b2b_r got %h exp %h", r_flat, 8'hE4); end
   endtask

   task automatic test_violation();
      fill(8'h90);
      n_vec++; if (b_flat !== 8'h90) begin n_err++; $display("FAIL viol_fill_b got %h exp %h", b_flat, 8'h90); end
      rotate(1'b0, 2'd1);
      n_vec++; if (b_flat !== 8'h24) begin n_err++; $display("FAIL viol_up1_b got %h exp %h", b_flat, 8'h24); end
      @(negedge clock);
      n_vec++; if (inv_ok !== 1'b0) begin n_err++; $display("FAIL viol_inv_ok got %b exp 0", inv_ok); end
      n_vec++; if (inv_err !== 1'b1) begin n_err++; $display("FAIL viol_inv_err got %b exp 1", inv_err); end
      rotate(1'b1, 2'd2);
      n_vec++; if (b_flat !== 8'h42) begin n_err++; $display("FAIL viol_down2_b got %h exp %h", b_flat, 8'h42); end
      n_vec++; if (offset !== 2'd3) begin n_err++; $display("FAIL viol_down2_offset got %0d exp 3", offset); end
      n_vec++; if (inv_err !== 1'b1) begin n_err++; $display("FAIL viol_sticky got %b exp 1", inv_err); end
      load_start = 1'b1;
      @(negedge clock);
      load_start = 1'b0;
      n_vec++; if (inv_err !== 1'b0) begin n_err++; $display("FAIL viol_clear got %b exp 0", inv_err); end
      n_vec++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL viol_ready got %b exp 1", load_ready); end
      n_vec++; if (offset !== 2'd0) begin n_err++; $display("FAIL viol_load_offset got %0d exp 0", offset); end
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1;
         load_data  = 2'(i);
         @(negedge clock);
      end
      load_valid = 1'b0;
      n_vec++; if (b_flat !== 8'hE4) begin n_err++; $display("FAIL viol_refill_b got %h exp %h", b_flat, 8'hE4); end
   endtask

   task automatic test_backpressure();
      rotate(1'b0, 2'd1);
      n_vec++; if (offset !== 2'd1) begin n_err++; $display("FAIL bp_pre_offset got %0d exp 1", offset); end
      load_start = 1'b1;
      @(negedge clock);
      load_start = 1'b0;
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy got %b exp 1", busy); end
      n_vec++; if (offset !== 2'd0) begin n_err++; $display("FAIL bp_offset got %0d exp 0", offset); end
      load_valid = 1'b1;
      load_data  = 2'd3;
      @(negedge clock);
      load_valid = 1'b0;
      n_vec++; if (b_flat !== 8'h3B) begin n_err++; $display("FAIL bp_beat0_b got %h exp %h", b_flat, 8'h3B); end
      n_vec++; if (r_flat !== 8'hE7) begin n_err++; $display("FAIL bp_beat0_r got %h exp %h", r_flat, 8'hE7); end
      for (int s = 0; s < 3; s++) begin
         en         = 1'b1;
         dir        = 1'b0;
         amt        = 2'd1;
         load_start = (s == 1);
         @(negedge clock);
         n_vec++; if (b_flat !== 8'h3B) begin n_err++; $display("FAIL bp_stall%0d_b got %h exp %h", s, b_flat, 8'h3B); end
         n_vec++; if (r_flat !== 8'hE7) begin n_err++; $display("FAIL bp_stall%0d_r got %h exp %h", s, r_flat, 8'hE7); end
         n_vec++; if (offset !== 2'd0) begin n_err++; $display("FAIL bp_stall%0d_offset got %0d exp 0", s, offset); end
         n_vec++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL bp_stall%0d_ready got %b exp 1", s, load_ready); end
      end
      en         = 1'b0;
      load_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1;
         load_data  = 2'(2 - i);
         @(negedge clock);
         if (i < 2) begin
            n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_beat%0d_busy got %b exp 1", i + 1, busy); end
         end else begin
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_done_busy got %b exp 0", busy); end
         end
      end
      load_valid = 1'b0;
      n_vec++; if (b_flat !== 8'h1B) begin n_err++; $display("FAIL bp_done_b got %h exp %h", b_flat, 8'h1B); end
      n_vec++; if (r_flat !== 8'h1B) begin n_err++; $display("FAIL bp_done_r got %h exp %h", r_flat, 8'h1B); end
   endtask

   task automatic test_reset_mid_load();
      load_start = 1'b1;
      @(negedge clock);
      load_start = 1'b0;
      load_valid = 1'b1;
      load_data  = 2'd1;
      @(negedge clock);
      load_data  = 2'd2;
      @(negedge clock);
      load_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      n_vec++; if (b_flat !== 8'h00) begin n_err++; $display("FAIL rst_mid_b got %h exp %h", b_flat, 8'h00); end
      n_vec++; if (r_flat !== 8'h00) begin n_err++; $display("FAIL rst_mid_r got %h exp %h", r_flat, 8'h00); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
      n_vec++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_ready got %b exp 0", load_ready); end
      n_vec++; if (inv_ok !== 1'b1) begin n_err++; $display("FAIL rst_mid_inv_ok got %b exp 1", inv_ok); end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      fill(8'hE4);
      n_vec++; if (b_flat !== 8'hE4) begin n_err++; $display("FAIL rst_refill_b got %h exp %h", b_flat, 8'hE4); end
      n_vec++; if (r_flat !== 8'hE4) begin n_err++; $display("FAIL rst_refill_r got %h exp %h", r_flat, 8'hE4); end
      rotate(1'b1, 2'd1);
      n_vec++; if (b_flat !== 8'h93) begin n_err++; $display("FAIL rst_down1_b got %h exp %h", b_flat, 8'h93); end
      n_vec++; if (offset !== 2'd3) begin n_err++; $display("FAIL rst_down1_offset got %0d exp 3", offset); end
      @(negedge clock);
      n_vec++; if (inv_ok !== 1'b1) begin n_err++; $display("FAIL rst_down1_inv_ok got %b exp 1", inv_ok); end
      n_vec++; if (inv_err !== 1'b0) begin n_err++; $display("FAIL rst_down1_inv_err got %b exp 0", inv_err); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      test_reset();
      test_fill_rotate_up();
      test_back_to_back();
      test_violation();
      test_backpressure();
      test_reset_mid_load();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
